// File: rtl/mips_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_mc
// Brief    : Multi-cycle MIPS ALU with single-cycle ops, shift-add MULU and
//            restoring DIVU, valid/ready handshake. DIVU built only when
//            MIPS_ALU_DIV_EN is defined.
// Revision : 1.0
// ============================================================================
module mips_alu_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy
);

    localparam int               c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    localparam logic [3:0] c_op_and  = 4'd0;
    localparam logic [3:0] c_op_or   = 4'd1;
    localparam logic [3:0] c_op_add  = 4'd2;
    localparam logic [3:0] c_op_xor  = 4'd3;
    localparam logic [3:0] c_op_nor  = 4'd4;
    localparam logic [3:0] c_op_sll  = 4'd5;
    localparam logic [3:0] c_op_srl  = 4'd6;
    localparam logic [3:0] c_op_sra  = 4'd7;
    localparam logic [3:0] c_op_sub  = 4'd8;
    localparam logic [3:0] c_op_slt  = 4'd9;
    localparam logic [3:0] c_op_sltu = 4'd10;
    localparam logic [3:0] c_op_mulu = 4'd11;
    localparam logic [3:0] c_op_divu = 4'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    // MUL: acc_hi = partial product high, acc_lo = multiplier/product low, opnd = multiplicand.
    // DIV: acc_hi = remainder, acc_lo = dividend/quotient, opnd = divisor.
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [WIDTH-1:0]     r_opnd;

    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_last;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_single;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH-1:0]     w_mul_hi;
    logic [WIDTH-1:0]     w_mul_lo;

    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (ctl == c_op_mulu);
    assign w_last   = (r_cnt == c_last);
    assign w_shamt  = b[SHAMT_W-1:0];

`ifdef MIPS_ALU_DIV_EN
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH-1:0]     w_div_diff;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [WIDTH-1:0]     w_div_q;

    assign w_is_div    = (ctl == c_op_divu);
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    assign w_div_q     = {r_acc_lo[WIDTH-2:0], w_div_ge};
`else
    assign w_is_div    = 1'b0;
`endif

    always_comb begin
        w_single = '0;
        case (ctl)
            c_op_and:  w_single = a & b;
            c_op_or:   w_single = a | b;
            c_op_add:  w_single = a + b;
            c_op_xor:  w_single = a ^ b;
            c_op_nor:  w_single = ~(a | b);
            c_op_sll:  w_single = a << w_shamt;
            c_op_srl:  w_single = a >> w_shamt;
            c_op_sra:  w_single = $signed(a) >>> w_shamt;
            c_op_sub:  w_single = a - b;
            c_op_slt:  w_single = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_sltu: w_single = {{(WIDTH-1){1'b0}}, (a < b)};
            default:   w_single = '0;
        endcase
    end

    // One shift-add step: conditionally add, then shift the 2*WIDTH accumulator right.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept && w_is_mul) begin
                    w_state_next = S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_opnd    <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            hi        <= '0;
            zero      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_acc_hi <= '0;
                            r_acc_lo <= b;
                            r_opnd   <= a;
                        end else if (w_is_div) begin
                            r_acc_hi <= '0;
                            r_acc_lo <= a;
                            r_opnd   <= b;
                        end else begin
                            out_valid <= 1'b1;
                            out       <= w_single;
                            hi        <= '0;
                            zero      <= (w_single == '0);
                        end
                    end
                end
                S_MUL: begin
                    r_acc_hi <= w_mul_hi;
                    r_acc_lo <= w_mul_lo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        out_valid <= 1'b1;
                        out       <= w_mul_lo;
                        hi        <= w_mul_hi;
                        zero      <= (w_mul_lo == '0);
                    end
                end
`ifdef MIPS_ALU_DIV_EN
                S_DIV: begin
                    r_acc_hi <= w_div_rem;
                    r_acc_lo <= w_div_q;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        out_valid <= 1'b1;
                        out       <= w_div_q;
                        hi        <= w_div_rem;
                        zero      <= (w_div_q == '0);
                    end
                end
`endif
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_alu_mc
// Brief    : Self-checking bench for mips_alu_mc against an arithmetic model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mips_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         zero;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_alu_mc #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ctl(ctl), .a(a), .b(b), .out_valid(out_valid), .out(out),
        .hi(hi), .zero(zero), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {hi, out} as the operation defines them.
    function automatic logic [63:0] ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        logic [31:0] fill;
        sh = y[4:0];
        fill = x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
        case (c)
            4'd0:  return {32'h0, x & y};
            4'd1:  return {32'h0, x | y};
            4'd2:  return {32'h0, x + y};
            4'd3:  return {32'h0, x ^ y};
            4'd4:  return {32'h0, ~(x | y)};
            4'd5:  return {32'h0, x << sh};
            4'd6:  return {32'h0, x >> sh};
            4'd7:  return {32'h0, (x >> sh) | fill};
            4'd8:  return {32'h0, x - y};
            4'd9:  return {32'h0, 31'h0, ($signed(x) < $signed(y))};
            4'd10: return {32'h0, 31'h0, (x < y)};
            4'd11: return 64'(x) * 64'(y);
`ifdef MIPS_ALU_DIV_EN
            4'd12: return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
`endif
            default: return 64'h0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] c);
`ifdef MIPS_ALU_DIV_EN
        if (c == 4'd12) return W + 1;
`endif
        return (c == 4'd11) ? W + 1 : 1;
    endfunction

    // Issues one op and waits for its result; returns one delay after the
    // out_valid edge so the next call accepts back-to-back.
    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] exp;
        int lat;
        exp = ref_alu(c, x, y);
        @(negedge clk);
        in_valid = 1'b1; ctl = c; a = x; b = y;
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; ctl = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            check({tag, "_busy"}, {in_ready, busy}, 2'b01);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, ref_lat(c));
        check({tag, "_out"}, out, exp[31:0]);
        check({tag, "_hi"}, hi, exp[63:32]);
        check({tag, "_zero"}, zero, (exp[31:0] == 0));
    endtask

    initial begin
        int seen;
        logic [31:0] held;
        logic [3:0]  rc;
        logic [31:0] ra, rb;

        rst = 1'b1; in_valid = 1'b0; ctl = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {in_ready, out_valid, out, hi, zero, busy}, {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0});
        @(negedge clk); rst = 1'b0;

        do_op("add", 4'd2, 32'd10, 32'd10);
        do_op("mulu", 4'd11, 32'd10, 32'd10);
        do_op("mulu_max", 4'd11, 32'hFFFF_FFFF, 32'd2);
        do_op("sub_b2b", 4'd8, 32'd5, 32'd5);
        do_op("divu", 4'd12, 32'd100, 32'd7);
        do_op("divu_z", 4'd12, 32'd9, 32'd0);
        do_op("slt", 4'd9, 32'hFFFF_FFFF, 32'd1);
        do_op("sltu", 4'd10, 32'hFFFF_FFFF, 32'd1);
        do_op("sra", 4'd7, 32'h8000_0000, 32'd31);
        do_op("sll_big", 4'd5, 32'h1234_5678, 32'd36);
        do_op("nor", 4'd4, 32'h0F0F_0000, 32'h0000_F0F0);
        do_op("illegal", 4'd14, 32'd3, 32'd4);
        do_op("mulu_full", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        held = out;
        repeat (3) @(posedge clk);
        #1;
        check("hold", {out_valid, out}, {1'b0, held});

        for (int i = 0; i < 24; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            do_op($sformatf("rnd%0d", i), rc, ra, rb);
        end

        @(negedge clk);
        in_valid = 1'b1; ctl = 4'd11; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; ctl = 4'd2; a = 32'd1; b = 32'd1;
        check("ign_rdy", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ign_nov", out_valid, 0);
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_rst", {in_ready, out_valid, out, hi, zero, busy}, {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0});
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        do_op("add_after", 4'd2, 32'd1, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
